// File: rtl/mdu_pkg.sv
// Shared constants, RV32M funct3 encodings and FSM state type for the multiply/divide unit.
package mdu_pkg;

  localparam int XLEN     = 32;
  localparam int ITER_CNT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step_i pulse.
module mdu_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  logic [W-1:0] rem_q, quo_q, dvs_q;
  logic [W-1:0] rem_d, quo_d;
  logic [W:0]   shifted, diff;

  // NOTE: every variable assigned here gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[W]) begin
      rem_d = shifted[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b0};
    end else begin
      rem_d = diff[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end
  end

  // NOTE: pure datapath registers carry no reset; control in the parent qualifies their use.
  always_ff @(posedge clk) begin
    if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit with fixed 32-step latency; define MDU_FAST_MUL_EN for a
// single-cycle combinational multiply path (divides stay iterative).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_index,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_rd_index,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [5:0]        cnt_q, cnt_d;
  logic              busy_q, done_q, wb_en_q;
  logic [4:0]        rd_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] prod_q;
  logic              accept, fast_path, mul_step, div_step;
  logic              neg_a_in, neg_b_in, neg_a, neg_b, div_zero, overflow;
  logic [XLEN-1:0]   mag_a_in, mag_b_in, quo, rem, result;
  logic [2*XLEN-1:0] prod_fix;

  assign accept   = (state_q == IDLE) && start;
  assign mul_step = (state_q == CALC) && !op_q[2];
  assign div_step = (state_q == CALC) && op_q[2];
  assign cnt_d    = cnt_q + 6'd1;
  assign neg_a_in = op_signed_a(funct3) & rs1_data[XLEN-1];
  assign neg_b_in = op_signed_b(funct3) & rs2_data[XLEN-1];
  assign mag_a_in = neg_a_in ? -rs1_data : rs1_data;
  assign mag_b_in = neg_b_in ? -rs2_data : rs2_data;

`ifdef MDU_FAST_MUL_EN
  // Low 64 bits of the product of sign-extended operands equal the exact signed product.
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{neg_a_in}}, rs1_data};
  assign fast_b    = {{XLEN{neg_b_in}}, rs2_data};
  assign fast_prod = fast_a * fast_b;
  assign fast_path = !funct3[2];
`else
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  assign fast_path = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cnt_q  <= '0;
          busy_q <= 1'b1;
          rd_q   <= rd_index;
          if (fast_path) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            wb_en_q <= (rd_index != '0);
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_d;
          if (cnt_d == 6'(ITER_CNT)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            wb_en_q <= (rd_q != '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wb_en_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= funct3;
      a_q  <= rs1_data;
      b_q  <= rs2_data;
`ifdef MDU_FAST_MUL_EN
      prod_q <= fast_prod;
    end
`else
      prod_q   <= '0;
      mcand_q  <= {{XLEN{1'b0}}, mag_a_in};
      mplier_q <= mag_b_in;
    end else if (mul_step) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
`endif
  end

  mdu_divider #(.W(XLEN)) u_div (
    .clk        (clk),
    .load_i     (accept),
    .step_i     (div_step),
    .dividend_i (mag_a_in),
    .divisor_i  (mag_b_in),
    .quotient_o (quo),
    .remainder_o(rem)
  );

  // Sign correction and RV32M special cases applied to the magnitude results.
  always_comb begin
    neg_a    = op_signed_a(op_q) & a_q[XLEN-1];
    neg_b    = op_signed_b(op_q) & b_q[XLEN-1];
    div_zero = (b_q == '0);
    overflow = (a_q == INT_MIN) && (b_q == '1);
`ifdef MDU_FAST_MUL_EN
    prod_fix = prod_q;
`else
    prod_fix = (neg_a ^ neg_b) ? -prod_q : prod_q;
`endif
    case (op_q)
      F3_MUL:                       result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV:  result = div_zero ? '1 : overflow ? INT_MIN : ((neg_a ^ neg_b) ? -quo : quo);
      F3_DIVU: result = div_zero ? '1 : quo;
      F3_REM:  result = div_zero ? a_q : overflow ? '0 : (neg_a ? -rem : rem);
      default: result = div_zero ? a_q : rem;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wb_en       = wb_en_q;
  assign wb_rd_index = rd_q;
  assign wb_data     = (state_q == DONE) ? result : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: random RV32M ops against an arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [4:0]  rd_index = '0;
  logic        busy, done, wb_en;
  logic [4:0]  wb_rd_index;
  logic [31:0] wb_data;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mul_div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .funct3     (funct3),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rd_index   (rd_index),
    .busy       (busy),
    .done       (done),
    .wb_en      (wb_en),
    .wb_rd_index(wb_rd_index),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    longint pa, pb;
    longint unsigned ua, ub;
    sa = a;
    sb = b;
    case (f3)
      F3_MUL: return a * b;
      F3_MULH: begin
        pa = sa; pb = sb;
        return 32'((pa * pb) >>> 32);
      end
      F3_MULHSU: begin
        pa = sa; pb = {32'd0, b};
        return 32'((pa * pb) >>> 32);
      end
      F3_MULHU: begin
        ua = {32'd0, a}; ub = {32'd0, b};
        return 32'((ua * ub) >> 32);
      end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3);
`ifdef MDU_FAST_MUL_EN
    return f3[2] ? 32 : 1;
`else
    return (f3 == f3) ? 32 : 32;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 with no outstanding request (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_data", wb_data, mon_e.data);
        check("wb_rd_index", wb_rd_index, mon_e.rd);
        check("wb_en", wb_en, mon_e.rd != 0);
        check("done_cycle", cyc, mon_e.t0 + mon_e.lat);
        check("busy_in_done", busy, 1'b1);
      end
    end else begin
      check("idle_outputs", {wb_en, wb_data}, 33'd0);
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", busy, 1'b0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    exp_t e;
    wait_idle();
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_index = rd;
    start    = 1'b1;
    e.data = ref_model(f3, a, b);
    e.rd   = rd;
    e.t0   = cyc + 1;
    e.lat  = lat_of(f3);
    sb_q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    funct3   = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_index = 5'($urandom);
  endtask

  initial begin
    exp_t e;
    int t0;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_wb_rd_index", wb_rd_index, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);

    // First start coincides with the first edge that sees rst_n high.
    rst_n = 1'b1;
    issue(F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    issue(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
    issue(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
    issue(F3_DIVU, 32'd100, 32'd0, 5'd6);
    issue(F3_REMU, 32'd100, 32'd0, 5'd7);
    issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    issue(F3_MUL, 32'd5, 32'd6, 5'd0);
    issue(F3_MUL, 32'd3, 32'd4, 5'd10);
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
    issue(F3_DIV, 32'h8000_0000, 32'd0, 5'd12);

    // start held high through CALC and DONE: only the IDLE cycle after DONE may accept it.
    wait_idle();
    funct3 = F3_DIVU; rs1_data = 32'd1000; rs2_data = 32'd7; rd_index = 5'd13;
    start = 1'b1;
    t0 = cyc + 1;
    e = '{ref_model(F3_DIVU, 32'd1000, 32'd7), 5'd13, t0, 32};
    sb_q.push_back(e);
    e.t0 = t0 + 34;
    sb_q.push_back(e);
    repeat (35) @(negedge clk);
    start = 1'b0;

    // Re-pulse at T0+5 is ignored, reset at T0+10 aborts with no done afterwards.
    wait_idle();
    funct3 = F3_DIV; rs1_data = 32'd77; rs2_data = 32'd5; rd_index = 5'd14;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_calc", busy, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_wb_en", wb_en, 1'b0);
    check("abort_wb_rd_index", wb_rd_index, 5'd0);
    check("abort_wb_data", wb_data, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_restart", busy, 1'b0);

    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        4: b = -($urandom_range(1, 15));
        default: ;
      endcase
      issue(3'($urandom), a, b, 5'($urandom));
    end

    for (int g = 0; g < 200 && sb_q.size() != 0; g++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  in  32  operand A, taken from the register-file rs1 read port.
REQ-007 rs2_data  in  32  operand B, taken from the register-file rs2 read port.
REQ-008 rd_index  in  5  destination register.
REQ-009 busy  out  1  high while not in IDLE; the core stalls on it.
REQ-010 done  out  1  one-cycle result-valid pulse.
REQ-011 wb_en  out  1  register-file write enable.
REQ-012 wb_rd_index  out  5  latched rd_index.
REQ-013 wb_data  out  32  result, valid only while done is high.

Function
REQ-014 Three states: IDLE, CALC, DONE.
- IDLE -> CALC on start.
- CALC -> DONE after 32 iteration steps.
- DONE -> IDLE unconditionally.
REQ-015 On accepting start (edge T0), operands, funct3 and rd_index are latched; later input changes have no effect.
REQ-016 Iteration counter: 6 bits, cleared at T0, incremented once per CALC cycle; CALC exits when it reaches 32.
REQ-017 Fixed latency: done = 1 in exactly the cycle following edge T0+32, for every op and operand value.
REQ-018 Multiply is radix-2 shift-add over 64-bit magnitudes.
- Sign handling: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
- MUL returns product[31:0]; the MULH* ops return product[63:32].
REQ-019 Divide is radix-2 restoring division on magnitudes.
- Quotient sign = sign(A) XOR sign(B) for DIV.
- Remainder sign = sign(A) for REM.
REQ-020 Divide-by-zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1. Latency is unchanged.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0. Latency is unchanged.
REQ-022 wb_en = done AND (wb_rd_index != 0).
REQ-023 start while busy is ignored; no queuing.
REQ-024 start in the DONE cycle is ignored; a new request needs start in IDLE, earliest one cycle after done.
REQ-025 Outside DONE, wb_data holds 0.

Reset
REQ-026 rst_n low at a rising edge forces IDLE and counter 0; busy, done, wb_en, wb_rd_index and wb_data all become 0.
REQ-027 Reset mid-CALC or in DONE aborts the operation; no done or wb_en pulse follows release.
REQ-028 First start is accepted at the first rising edge with rst_n high.

Configuration
REQ-029 Macro MDU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a combinational 64-bit product.
- Path: IDLE -> DONE directly; done is asserted in the cycle following T0.
- Divide ops keep the 32-step path.
REQ-030 Macro undefined: all ops use the iterative path and the REQ-017 latency.

Structure
REQ-031 Package mdu_pkg holds:
- XLEN;
- funct3 encodings as named constants;
- the state enum (IDLE, CALC, DONE);
- the iteration count constant (32).
REQ-032 Sub-module mdu_divider holds the restoring-division datapath: remainder/quotient registers, one step per enable, magnitude in, magnitude out. Control, sign correction and the special cases stay in mul_div_unit.

Verification
REQ-033 MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd = 5 -> done at T0+32, wb_data 0xFFFFFFEB, wb_en 1, wb_rd_index 5.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> wb_data 0xFFFFFFFE; MULH on the same operands -> 0x00000000.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 % 0 -> 100.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; both with done at T0+32.
REQ-037 start at T0, start re-pulsed at T0+5, rst_n low at T0+10 -> re-pulse ignored, all outputs 0 after T0+10, no done afterwards.
REQ-038 MUL with rd = 0 -> done 1, wb_en 0; with MDU_FAST_MUL_EN, MUL 3 x 4 -> done at T0+1, wb_data 12.
